te_multiport_block_fsm: RTL and testbench

- Parametrised successor of the single-port connector FSM.
- Sits between the CVA6 commit stage (NR_COMMIT_PORTS uop entries per cycle) and the trace encoder ingress.
- Accumulates retired instructions into E-Trace instruction blocks. Emits up to NR_COMMIT_PORTS closed blocks per cycle, packed onto output channels from 0 upward.
- Adds over the single-port version: multi-port commit, iretire saturation splitting, and explicit flush.

---
 rtl/connector_pkg.sv | 38 +++
 rtl/te_block_step.sv | 90 +++++++++
 rtl/te_multiport_block_fsm.sv | 187 ++++++++++++++++++
 tb/tb_te_multiport_block_fsm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/connector_pkg.sv
// Shared types and widths for the multi-port commit-to-trace block connector.
package connector_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned IRETIRE_LEN = 8;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    localparam logic [ITYPE_LEN-1:0] ITYPE_STD   = ITYPE_LEN'(0);
    localparam logic [ITYPE_LEN-1:0] ITYPE_EXC   = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] ITYPE_INT   = ITYPE_LEN'(2);
    localparam logic [ITYPE_LEN-1:0] ITYPE_ERET  = ITYPE_LEN'(3);
    localparam logic [ITYPE_LEN-1:0] ITYPE_NTBR  = ITYPE_LEN'(4);
    localparam logic [ITYPE_LEN-1:0] ITYPE_TBR   = ITYPE_LEN'(5);
    localparam logic [ITYPE_LEN-1:0] ITYPE_UNINF = ITYPE_LEN'(6);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic                 compressed;
        logic [ITYPE_LEN-1:0] itype;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } uop_entry_s;

    // Exceptions and interrupts report a uop that did not retire.
    function automatic logic is_trap(input logic [ITYPE_LEN-1:0] itype);
        return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
    endfunction

endpackage

// File: rtl/te_block_step.sv
// Combinational single-uop step: folds one commit entry into the open block
// and optionally closes it.
module te_block_step
    import connector_pkg::*;
#(
    parameter int unsigned IRETIRE_LEN = connector_pkg::IRETIRE_LEN
) (
    input  state_e                  state_i,
    input  logic [XLEN-1:0]         iaddr_i,
    input  logic [IRETIRE_LEN-1:0]  count_i,
    input  logic                    lastsize_i,
    input  logic [PRIV_LEN-1:0]     priv_i,
    input  uop_entry_s              uop_i,
    output state_e                  state_c,
    output logic [XLEN-1:0]         iaddr_c,
    output logic [IRETIRE_LEN-1:0]  count_c,
    output logic                    lastsize_c,
    output logic [PRIV_LEN-1:0]     priv_c,
    output logic                    emit_c,
    output logic [IRETIRE_LEN-1:0]  e_iretire_c,
    output logic                    e_ilastsize_c,
    output logic [ITYPE_LEN-1:0]    e_itype_c,
    output logic [CAUSE_LEN-1:0]    e_cause_c,
    output logic [XLEN-1:0]         e_tval_c,
    output logic [PRIV_LEN-1:0]     e_priv_c,
    output logic [XLEN-1:0]         e_iaddr_c
);

    localparam int unsigned IRETIRE_MAX = (1 << IRETIRE_LEN) - 1;
    localparam logic [IRETIRE_LEN-1:0] SAT_LVL = IRETIRE_LEN'(IRETIRE_MAX - 1);

    logic                   open_c;
    logic [IRETIRE_LEN-1:0] base_count_c;
    logic [XLEN-1:0]        base_iaddr_c;
    logic [IRETIRE_LEN-1:0] sum_c;

    assign open_c       = (state_i == ST_ACCUM);
    assign base_count_c = open_c ? count_i : '0;
    assign base_iaddr_c = open_c ? iaddr_i : uop_i.pc;
    assign sum_c        = base_count_c + (uop_i.compressed ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));

    always_comb begin
        state_c       = state_i;
        iaddr_c       = iaddr_i;
        count_c       = count_i;
        lastsize_c    = lastsize_i;
        priv_c        = priv_i;
        emit_c        = 1'b0;
        e_iretire_c   = '0;
        e_ilastsize_c = 1'b0;
        e_itype_c     = '0;
        e_cause_c     = '0;
        e_tval_c      = '0;
        e_priv_c      = '0;
        e_iaddr_c     = '0;

        if (uop_i.valid) begin
            if (is_trap(uop_i.itype)) begin
                emit_c        = 1'b1;
                e_iretire_c   = base_count_c;
                e_ilastsize_c = open_c ? lastsize_i : 1'b0;
                e_itype_c     = uop_i.itype;
                e_cause_c     = uop_i.cause;
                e_tval_c      = uop_i.tval;
                e_priv_c      = uop_i.priv;
                e_iaddr_c     = base_iaddr_c;
                state_c       = ST_IDLE;
                count_c       = '0;
            end else begin
                state_c    = ST_ACCUM;
                iaddr_c    = base_iaddr_c;
                count_c    = sum_c;
                lastsize_c = ~uop_i.compressed;
                priv_c     = uop_i.priv;
                // Discontinuities keep their own itype; saturation closes as STD.
                if ((uop_i.itype != ITYPE_STD) || (sum_c >= SAT_LVL)) begin
                    emit_c        = 1'b1;
                    e_iretire_c   = sum_c;
                    e_ilastsize_c = ~uop_i.compressed;
                    e_itype_c     = uop_i.itype;
                    e_priv_c      = uop_i.priv;
                    e_iaddr_c     = base_iaddr_c;
                    state_c       = ST_IDLE;
                    count_c       = '0;
                end
            end
        end
    end

endmodule

// File: rtl/te_multiport_block_fsm.sv
// Multi-port commit to E-Trace block connector: chains per-port steps and packs
// closed blocks onto output channels from 0 upward.
module te_multiport_block_fsm
    import connector_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = connector_pkg::XLEN,
    parameter int unsigned IRETIRE_LEN     = connector_pkg::IRETIRE_LEN,
    parameter int unsigned ITYPE_LEN       = connector_pkg::ITYPE_LEN,
    parameter int unsigned CAUSE_LEN       = connector_pkg::CAUSE_LEN,
    parameter int unsigned PRIV_LEN        = connector_pkg::PRIV_LEN
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  uop_entry_s [NR_COMMIT_PORTS-1:0]             uop_entry_i,
    input  logic                                         flush_i,
    output logic [NR_COMMIT_PORTS-1:0]                   valid_o,
    output logic [NR_COMMIT_PORTS-1:0][IRETIRE_LEN-1:0]  iretire_o,
    output logic [NR_COMMIT_PORTS-1:0]                   ilastsize_o,
    output logic [NR_COMMIT_PORTS-1:0][ITYPE_LEN-1:0]    itype_o,
    output logic [NR_COMMIT_PORTS-1:0][CAUSE_LEN-1:0]    cause_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]         tval_o,
    output logic [NR_COMMIT_PORTS-1:0][PRIV_LEN-1:0]     priv_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]         iaddr_o
);

    localparam int unsigned NP = NR_COMMIT_PORTS;

    state_e                          state_q, state_d;
    logic [connector_pkg::XLEN-1:0]  iaddr_q, iaddr_d;
    logic [IRETIRE_LEN-1:0]          count_q, count_d;
    logic                            lastsize_q, lastsize_d;
    logic [connector_pkg::PRIV_LEN-1:0] priv_q, priv_d;

    logic [NP-1:0]                   valid_q, valid_d;
    logic [NP-1:0][IRETIRE_LEN-1:0]  iretire_q, iretire_d;
    logic [NP-1:0]                   ilastsize_q, ilastsize_d;
    logic [NP-1:0][ITYPE_LEN-1:0]    itype_q, itype_d;
    logic [NP-1:0][CAUSE_LEN-1:0]    cause_q, cause_d;
    logic [NP-1:0][XLEN-1:0]         tval_q, tval_d;
    logic [NP-1:0][PRIV_LEN-1:0]     priv_o_q, priv_o_d;
    logic [NP-1:0][XLEN-1:0]         iaddr_o_q, iaddr_o_d;

    state_e                             st  [NP+1];
    logic [connector_pkg::XLEN-1:0]     ia  [NP+1];
    logic [IRETIRE_LEN-1:0]             cnt [NP+1];
    logic                               ls  [NP+1];
    logic [connector_pkg::PRIV_LEN-1:0] pv  [NP+1];

    logic [NP-1:0]                          emit;
    logic [IRETIRE_LEN-1:0]                 e_iretire   [NP];
    logic                                   e_ilastsize [NP];
    logic [connector_pkg::ITYPE_LEN-1:0]    e_itype     [NP];
    logic [connector_pkg::CAUSE_LEN-1:0]    e_cause     [NP];
    logic [connector_pkg::XLEN-1:0]         e_tval      [NP];
    logic [connector_pkg::PRIV_LEN-1:0]     e_priv      [NP];
    logic [connector_pkg::XLEN-1:0]         e_iaddr     [NP];

    int unsigned rank [NP];
    int unsigned n_emit;
    logic        flush_emit;

    assign st[0]  = state_q;
    assign ia[0]  = iaddr_q;
    assign cnt[0] = count_q;
    assign ls[0]  = lastsize_q;
    assign pv[0]  = priv_q;

    for (genvar g = 0; g < NP; g++) begin : g_step
        te_block_step #(
            .IRETIRE_LEN (IRETIRE_LEN)
        ) u_step (
            .state_i       (st[g]),
            .iaddr_i       (ia[g]),
            .count_i       (cnt[g]),
            .lastsize_i    (ls[g]),
            .priv_i        (pv[g]),
            .uop_i         (uop_entry_i[g]),
            .state_c       (st[g+1]),
            .iaddr_c       (ia[g+1]),
            .count_c       (cnt[g+1]),
            .lastsize_c    (ls[g+1]),
            .priv_c        (pv[g+1]),
            .emit_c        (emit[g]),
            .e_iretire_c   (e_iretire[g]),
            .e_ilastsize_c (e_ilastsize[g]),
            .e_itype_c     (e_itype[g]),
            .e_cause_c     (e_cause[g]),
            .e_tval_c      (e_tval[g]),
            .e_priv_c      (e_priv[g]),
            .e_iaddr_c     (e_iaddr[g])
        );
    end

    // Next state plus channel packing: k-th closure of the cycle lands on channel k.
    always_comb begin
        n_emit = 0;
        for (int unsigned p = 0; p < NP; p++) begin
            rank[p] = n_emit;
            if (emit[p]) n_emit = n_emit + 1;
        end

        state_d     = st[NP];
        iaddr_d     = ia[NP];
        count_d     = cnt[NP];
        lastsize_d  = ls[NP];
        priv_d      = pv[NP];
        flush_emit  = flush_i && (st[NP] == ST_ACCUM);
        if (flush_emit) begin
            state_d = ST_IDLE;
            count_d = '0;
        end

        valid_d     = '0;
        iretire_d   = '0;
        ilastsize_d = '0;
        itype_d     = '0;
        cause_d     = '0;
        tval_d      = '0;
        priv_o_d    = '0;
        iaddr_o_d   = '0;

        for (int unsigned c = 0; c < NP; c++) begin
            for (int unsigned p = 0; p < NP; p++) begin
                if (emit[p] && (rank[p] == c)) begin
                    valid_d[c]     = 1'b1;
                    iretire_d[c]   = e_iretire[p];
                    ilastsize_d[c] = e_ilastsize[p];
                    itype_d[c]     = ITYPE_LEN'(e_itype[p]);
                    cause_d[c]     = CAUSE_LEN'(e_cause[p]);
                    tval_d[c]      = XLEN'(e_tval[p]);
                    priv_o_d[c]    = PRIV_LEN'(e_priv[p]);
                    iaddr_o_d[c]   = XLEN'(e_iaddr[p]);
                end
            end
            if (flush_emit && (n_emit == c)) begin
                valid_d[c]     = 1'b1;
                iretire_d[c]   = cnt[NP];
                ilastsize_d[c] = ls[NP];
                priv_o_d[c]    = PRIV_LEN'(pv[NP]);
                iaddr_o_d[c]   = XLEN'(ia[NP]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            iaddr_q     <= '0;
            count_q     <= '0;
            lastsize_q  <= 1'b0;
            priv_q      <= '0;
            valid_q     <= '0;
            iretire_q   <= '0;
            ilastsize_q <= '0;
            itype_q     <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            priv_o_q    <= '0;
            iaddr_o_q   <= '0;
        end else begin
            state_q     <= state_d;
            iaddr_q     <= iaddr_d;
            count_q     <= count_d;
            lastsize_q  <= lastsize_d;
            priv_q      <= priv_d;
            valid_q     <= valid_d;
            iretire_q   <= iretire_d;
            ilastsize_q <= ilastsize_d;
            itype_q     <= itype_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            priv_o_q    <= priv_o_d;
            iaddr_o_q   <= iaddr_o_d;
        end
    end

    assign valid_o     = valid_q;
    assign iretire_o   = iretire_q;
    assign ilastsize_o = ilastsize_q;
    assign itype_o     = itype_q;
    assign cause_o     = cause_q;
    assign tval_o      = tval_q;
    assign priv_o      = priv_o_q;
    assign iaddr_o     = iaddr_o_q;

endmodule

// File: tb/tb_te_multiport_block_fsm.sv
// Scoreboard bench: directed commit patterns push expected blocks; negedge monitors pop and compare.
module tb_te_multiport_block_fsm;
    import connector_pkg::*;

    localparam int unsigned NP = 2;

    typedef struct {
        int unsigned ch;
        logic [7:0]  iretire;
        logic        ilastsize;
        logic [2:0]  itype;
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [1:0]  priv;
        logic [63:0] iaddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default IRETIRE_LEN = 8
    uop_entry_s [NP-1:0]   a_uop;
    logic                  a_flush;
    logic [NP-1:0]         a_valid;
    logic [NP-1:0][7:0]    a_iretire;
    logic [NP-1:0]         a_ilastsize;
    logic [NP-1:0][2:0]    a_itype;
    logic [NP-1:0][4:0]    a_cause;
    logic [NP-1:0][63:0]   a_tval;
    logic [NP-1:0][1:0]    a_priv;
    logic [NP-1:0][63:0]   a_iaddr;

    // Instance B: IRETIRE_LEN = 4 for saturation
    uop_entry_s [NP-1:0]   b_uop;
    logic                  b_flush;
    logic [NP-1:0]         b_valid;
    logic [NP-1:0][3:0]    b_iretire;
    logic [NP-1:0]         b_ilastsize;
    logic [NP-1:0][2:0]    b_itype;
    logic [NP-1:0][4:0]    b_cause;
    logic [NP-1:0][63:0]   b_tval;
    logic [NP-1:0][1:0]    b_priv;
    logic [NP-1:0][63:0]   b_iaddr;

    te_multiport_block_fsm #(.NR_COMMIT_PORTS(NP)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .uop_entry_i(a_uop), .flush_i(a_flush),
        .valid_o(a_valid), .iretire_o(a_iretire), .ilastsize_o(a_ilastsize),
        .itype_o(a_itype), .cause_o(a_cause), .tval_o(a_tval),
        .priv_o(a_priv), .iaddr_o(a_iaddr)
    );

    te_multiport_block_fsm #(.NR_COMMIT_PORTS(NP), .IRETIRE_LEN(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .uop_entry_i(b_uop), .flush_i(b_flush),
        .valid_o(b_valid), .iretire_o(b_iretire), .ilastsize_o(b_ilastsize),
        .itype_o(b_itype), .cause_o(b_cause), .tval_o(b_tval),
        .priv_o(b_priv), .iaddr_o(b_iaddr)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic uop_entry_s mk(input logic [63:0] pc, input logic comp,
                                      input logic [2:0] it, input logic [4:0] cause,
                                      input logic [63:0] tval, input logic [1:0] priv);
        uop_entry_s u;
        u.valid = 1'b1; u.pc = pc; u.compressed = comp; u.itype = it;
        u.cause = cause; u.tval = tval; u.priv = priv;
        return u;
    endfunction

    function automatic exp_t ex(input int unsigned ch, input logic [7:0] ir, input logic ls,
                                input logic [2:0] it, input logic [4:0] cause,
                                input logic [63:0] tval, input logic [1:0] priv,
                                input logic [63:0] iaddr);
        exp_t e;
        e.ch = ch; e.iretire = ir; e.ilastsize = ls; e.itype = it;
        e.cause = cause; e.tval = tval; e.priv = priv; e.iaddr = iaddr;
        return e;
    endfunction

    task automatic check_blk(input string tag, input int unsigned ch, input logic [7:0] ir,
                             input logic ls, input logic [2:0] it, input logic [4:0] cause,
                             input logic [63:0] tval, input logic [1:0] priv, input logic [63:0] iaddr,
                             input int has_exp, input exp_t e);
        checks++;
        if (!has_exp) begin
            $display("FAIL %s unexpected block ch=%0d iretire=%0d itype=%0d iaddr=%h (required: none)",
                     tag, ch, ir, it, iaddr);
        end else if (e.ch == ch && e.iretire == ir && e.ilastsize == ls && e.itype == it &&
                     e.cause == cause && e.tval == tval && e.priv == priv && e.iaddr == iaddr) begin
            passes++;
        end else begin
            $display("FAIL %s got ch=%0d ir=%0d ls=%0d it=%0d cause=%0d tval=%h priv=%0d iaddr=%h required ch=%0d ir=%0d ls=%0d it=%0d cause=%0d tval=%h priv=%0d iaddr=%h",
                     tag, ch, ir, ls, it, cause, tval, priv, iaddr,
                     e.ch, e.iretire, e.ilastsize, e.itype, e.cause, e.tval, e.priv, e.iaddr);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < NP; c++) begin
            if (a_valid[c]) begin
                e = ex(0, 0, 0, 0, 0, 0, 0, 0);
                if (qa.size() != 0) e = qa.pop_front();
                check_blk("blk_a", c, a_iretire[c], a_ilastsize[c], a_itype[c], a_cause[c],
                          a_tval[c], a_priv[c], a_iaddr[c], (e.iaddr != 0 || e.itype != 0 || e.iretire != 0) ? 1 : 0, e);
            end
            if (b_valid[c]) begin
                e = ex(0, 0, 0, 0, 0, 0, 0, 0);
                if (qb.size() != 0) e = qb.pop_front();
                check_blk("blk_b", c, {4'b0, b_iretire[c]}, b_ilastsize[c], b_itype[c], b_cause[c],
                          b_tval[c], b_priv[c], b_iaddr[c], (e.iaddr != 0 || e.itype != 0 || e.iretire != 0) ? 1 : 0, e);
            end
        end
    end

    task automatic drive_a(input uop_entry_s u0, input uop_entry_s u1, input logic fl);
        a_uop[0] = u0; a_uop[1] = u1; a_flush = fl;
        @(posedge clk); #1;
        a_uop = '0; a_flush = 1'b0;
    endtask

    task automatic drive_b(input uop_entry_s u0, input uop_entry_s u1);
        b_uop[0] = u0; b_uop[1] = u1;
        @(posedge clk); #1;
        b_uop = '0;
    endtask

    task automatic check_zero(input string tag, input logic is_a);
        logic z;
        checks++;
        if (is_a) z = (a_valid == 0) && (a_iretire == 0) && (a_ilastsize == 0) && (a_itype == 0) &&
                      (a_cause == 0) && (a_tval == 0) && (a_priv == 0) && (a_iaddr == 0);
        else      z = (b_valid == 0) && (b_iretire == 0) && (b_ilastsize == 0) && (b_itype == 0) &&
                      (b_cause == 0) && (b_tval == 0) && (b_priv == 0) && (b_iaddr == 0);
        if (z) passes++;
        else $display("FAIL %s outputs not all zero: valid_a=%b valid_b=%b iaddr_a0=%h (required 0)",
                      tag, a_valid, b_valid, a_iaddr[0]);
    endtask

    uop_entry_s none;

    initial begin
        none = '0;
        rst_n = 1'b0;
        a_uop = '0; a_flush = 1'b0;
        b_uop = '0; b_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_a", 1'b1);
        check_zero("reset_b", 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // std then TBR on consecutive cycles
        drive_a(mk(64'h1000, 0, ITYPE_STD, 0, 0, 3), none, 0);
        qa.push_back(ex(0, 4, 1, 5, 0, 0, 3, 64'h1000));
        drive_a(mk(64'h1004, 0, ITYPE_TBR, 0, 0, 3), none, 0);

        // two closures in one cycle
        qa.push_back(ex(0, 1, 0, 4, 0, 0, 1, 64'h2000));
        qa.push_back(ex(1, 2, 1, 5, 0, 0, 1, 64'h2002));
        drive_a(mk(64'h2000, 1, ITYPE_NTBR, 0, 0, 1), mk(64'h2002, 0, ITYPE_TBR, 0, 0, 1), 0);

        // 6-halfword block closed by EXC, then INT from IDLE on port 1
        drive_a(mk(64'h3000, 0, ITYPE_STD, 0, 0, 0), mk(64'h3004, 0, ITYPE_STD, 0, 0, 0), 0);
        drive_a(mk(64'h3008, 0, ITYPE_STD, 0, 0, 0), none, 0);
        qa.push_back(ex(0, 6, 1, 1, 2, 64'hDEAD, 3, 64'h3000));
        qa.push_back(ex(1, 0, 0, 2, 5, 64'h40, 1, 64'h4000));
        drive_a(mk(64'h300C, 0, ITYPE_EXC, 2, 64'hDEAD, 3), mk(64'h4000, 0, ITYPE_INT, 5, 64'h40, 1), 0);

        // flush closes a 4-halfword block
        qa.push_back(ex(0, 4, 1, 0, 0, 0, 2, 64'h6000));
        drive_a(mk(64'h6000, 0, ITYPE_STD, 0, 0, 2), mk(64'h6004, 0, ITYPE_STD, 0, 0, 2), 1);

        // flush after every port closed: nothing extra
        qa.push_back(ex(0, 2, 1, 5, 0, 0, 0, 64'h6100));
        qa.push_back(ex(1, 1, 0, 3, 0, 0, 1, 64'h6200));
        drive_a(mk(64'h6100, 0, ITYPE_TBR, 0, 0, 0), mk(64'h6200, 1, ITYPE_ERET, 0, 0, 1), 1);

        // saturation at IRETIRE_LEN = 4: seventh 32-bit uop reaches 14
        drive_b(mk(64'h5000, 0, ITYPE_STD, 0, 0, 0), mk(64'h5002, 0, ITYPE_STD, 0, 0, 0));
        drive_b(mk(64'h5004, 0, ITYPE_STD, 0, 0, 0), mk(64'h5006, 0, ITYPE_STD, 0, 0, 0));
        drive_b(mk(64'h5008, 0, ITYPE_STD, 0, 0, 0), mk(64'h500A, 0, ITYPE_STD, 0, 0, 0));
        qb.push_back(ex(0, 14, 1, 0, 0, 0, 0, 64'h5000));
        qb.push_back(ex(1, 2, 1, 5, 0, 0, 0, 64'h500E));
        drive_b(mk(64'h500C, 0, ITYPE_STD, 0, 0, 0), mk(64'h500E, 0, ITYPE_TBR, 0, 0, 0));

        // 13 halfwords plus a 32-bit uop lands exactly on IRETIRE_MAX
        drive_b(mk(64'h7000, 0, ITYPE_STD, 0, 0, 2), mk(64'h7004, 0, ITYPE_STD, 0, 0, 2));
        drive_b(mk(64'h7008, 0, ITYPE_STD, 0, 0, 2), mk(64'h700C, 0, ITYPE_STD, 0, 0, 2));
        drive_b(mk(64'h7010, 0, ITYPE_STD, 0, 0, 2), mk(64'h7014, 0, ITYPE_STD, 0, 0, 2));
        qb.push_back(ex(0, 15, 1, 0, 0, 0, 2, 64'h7000));
        drive_b(mk(64'h7018, 1, ITYPE_STD, 0, 0, 2), mk(64'h701A, 0, ITYPE_STD, 0, 0, 2));

        // reset while a block pulse is out and a new block is open
        qa.push_back(ex(0, 1, 0, 5, 0, 0, 0, 64'h8000));
        drive_a(mk(64'h8000, 1, ITYPE_TBR, 0, 0, 0), mk(64'h8002, 0, ITYPE_STD, 0, 0, 0), 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_block", 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_a(none, none, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        checks++;
        if (qa.size() == 0) passes++;
        else $display("FAIL drain_a %0d blocks never seen (required 0)", qa.size());
        checks++;
        if (qb.size() == 0) passes++;
        else $display("FAIL drain_b %0d blocks never seen (required 0)", qb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
